// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared encodings for the ARM multi-cycle instruction sequencer
// Contents: state encoding, opcode classes, rf_wsel/addr_sel codes, ARM condition codes,
//           and small opcode-classification helpers.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB_RD  = 3'd5,
    ST_WB_RN  = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [4:0] OP_LDST    = 5'b10000;
  localparam logic [4:0] OP_BRANCH  = 5'b10001;
  localparam logic [4:0] OP_INVALID = 5'b11111;
  // Compare/test group (TST, TEQ, CMP, CMN): flags only, no register result
  localparam logic [4:0] OP_CMP_LO  = 5'b01000;
  localparam logic [4:0] OP_CMP_HI  = 5'b01011;

  localparam logic [1:0] WSEL_RD_ALU = 2'd0;
  localparam logic [1:0] WSEL_RD_MEM = 2'd1;
  localparam logic [1:0] WSEL_RN_ALU = 2'd2;
  localparam logic [1:0] WSEL_LR_PC  = 2'd3;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_RN  = 2'd1;
  localparam logic [1:0] ADDR_ALU = 2'd2;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic logic is_data_proc(input logic [4:0] op);
    return ~op[4];
  endfunction

  function automatic logic is_compare(input logic [4:0] op);
    return (op >= OP_CMP_LO) && (op <= OP_CMP_HI);
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluator
// Ports: cond  [3:0] condition field of the instruction
//        flags [3:0] CPSR NZCV (bit3 = N)
//        pass        1 when the instruction should execute
module cond_check
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      // NV never executes
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle control FSM for the ARM datapath
// Inputs : clk, reset (async active-low), run, decoded fields (opcode, cond, flags,
//          cpsr_write, load_store, pre_post, write_back, link_bit), mem_ack
// Outputs: datapath enables (fetch_req, ir_load, pc_inc, pc_branch, alu_en, flags_we,
//          mem_req, mem_we, addr_sel, rf_we, rf_wsel), sticky fault, debug state,
//          retired-instruction counter instr_count
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [3:0]       cond,
  input  logic [3:0]       flags,
  input  logic             cpsr_write,
  input  logic             load_store,
  input  logic             pre_post,
  input  logic             write_back,
  input  logic             link_bit,
  input  logic             mem_ack,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             alu_en,
  output logic             flags_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       addr_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  // The wait counter reaching MEM_WAIT_MAX is detected one count early so the
  // transition to FAULT happens on the edge where the count would hit the limit.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     cur_state, nxt_state;
  logic [7:0] wait_cnt;
  logic       cond_pass;
  logic       retire;
  logic       base_update;
  logic       waiting;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Post-indexed transfers always write the updated base back
  assign base_update = write_back | ~pre_post;
  assign waiting     = (cur_state == ST_FETCH) || (cur_state == ST_MEM);
  assign state       = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= ST_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      cur_state <= nxt_state;
      // Outside FETCH/MEM the counter sits at zero, which also gives the
      // clear-on-entry behaviour for free.
      if (waiting && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    retire    = 1'b0;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    alu_en    = 1'b0;
    flags_we  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = ADDR_PC;
    rf_we     = 1'b0;
    rf_wsel   = WSEL_RD_ALU;
    fault     = 1'b0;

    case (cur_state)
      ST_IDLE: begin
        if (run) nxt_state = ST_FETCH;
      end

      ST_FETCH: begin
        fetch_req = 1'b1;
        addr_sel  = ADDR_PC;
        if (mem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          nxt_state = ST_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt_state = ST_FAULT;
        end
      end

      ST_DECODE: begin
        if (opcode == OP_INVALID) begin
          nxt_state = ST_FAULT;
        end else if (!cond_pass) begin
          retire = 1'b1;
        end else begin
          nxt_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_data_proc(opcode)) begin
          alu_en   = 1'b1;
          flags_we = cpsr_write | is_compare(opcode);
          if (!is_compare(opcode)) begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_RD_ALU;
          end
          retire = 1'b1;
        end else if (opcode == OP_BRANCH) begin
          pc_branch = 1'b1;
          if (link_bit) begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_LR_PC;
          end
          retire = 1'b1;
        end else if (opcode == OP_LDST) begin
          alu_en    = 1'b1;
          nxt_state = ST_MEM;
        end else begin
          // Unassigned opcodes retire as no-ops
          retire = 1'b1;
        end
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = ~load_store;
        addr_sel = pre_post ? ADDR_ALU : ADDR_RN;
        if (mem_ack) begin
          if (load_store) begin
            nxt_state = ST_WB_RD;
          end else if (base_update) begin
            nxt_state = ST_WB_RN;
          end else begin
            retire = 1'b1;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          nxt_state = ST_FAULT;
        end
      end

      ST_WB_RD: begin
        rf_we   = 1'b1;
        rf_wsel = WSEL_RD_MEM;
        if (base_update) begin
          nxt_state = ST_WB_RN;
        end else begin
          retire = 1'b1;
        end
      end

      ST_WB_RN: begin
        rf_we   = 1'b1;
        rf_wsel = WSEL_RN_ALU;
        retire  = 1'b1;
      end

      ST_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        nxt_state = ST_FAULT;
      end
    endcase

    if (retire) begin
      nxt_state = run ? ST_FETCH : ST_IDLE;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard testbench for instr_sequencer
module tb_instr_sequencer;

  localparam int MAXW = 4;
  localparam int CW   = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       fetch_req;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_branch;
    logic       alu_en;
    logic       flags_we;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       fault;
    logic [3:0] cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [4:0]    opcode;
  logic [3:0]    cond;
  logic [3:0]    flags;
  logic          cpsr_write, load_store, pre_post, write_back, link_bit, mem_ack;
  logic          fetch_req, ir_load, pc_inc, pc_branch, alu_en, flags_we, mem_req, mem_we;
  logic [1:0]    addr_sel;
  logic          rf_we;
  logic [1:0]    rf_wsel;
  logic          fault;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  instr_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .cond(cond), .flags(flags),
    .cpsr_write(cpsr_write), .load_store(load_store), .pre_post(pre_post),
    .write_back(write_back), .link_bit(link_bit), .mem_ack(mem_ack),
    .fetch_req(fetch_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .alu_en(alu_en), .flags_we(flags_we), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .rf_we(rf_we), .rf_wsel(rf_wsel), .fault(fault),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model state
  int m_cnt       = 0;
  bit m_idle      = 1'b1;
  int abort_mem_k = -1;

  // Monitor: compares every cycle that has an expectation queued
  always @(negedge clk) begin
    obs_t a, e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{st: state, fetch_req: fetch_req, ir_load: ir_load, pc_inc: pc_inc,
            pc_branch: pc_branch, alu_en: alu_en, flags_we: flags_we, mem_req: mem_req,
            mem_we: mem_we, addr_sel: addr_sel, rf_we: rf_we, rf_wsel: rf_wsel,
            fault: fault, cnt: instr_count};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle %0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 cyc, a.st, a, e.st, e);
      end
    end
  end

  // ARM condition rule: odd codes are the negation of the preceding even code
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st  = st;
    e.cnt = 4'(m_cnt);
    return e;
  endfunction

  task automatic push_step(input obs_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic retire_m(input bit rv);
    m_cnt  = (m_cnt + 1) % (1 << CW);
    m_idle = !rv;
  endtask

  task automatic fault_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      run     = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      e       = blank(3'd7);
      e.fault = 1'b1;
      push_step(e);
    end
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      run     = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      push_step(blank(3'd0));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_cnt = 0;
    run   = 1'b1;
    push_step(blank(3'd0));
    push_step(blank(3'd0));
    reset  = 1'b1;
    m_idle = 1'b1;
  endtask

  // Walks one instruction through the reference rules. fw/mw: cycles of wait
  // before mem_ack in FETCH/MEM; rv: run level from DECODE on.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] cnd, input logic [3:0] fl,
                           input bit s, input bit ls, input bit pp, input bit wbk,
                           input bit lnk, input int fw, input int mw, input bit rv);
    obs_t e;
    bit   cmp, base;
    opcode = op; cond = cnd; flags = fl; cpsr_write = s; load_store = ls;
    pre_post = pp; write_back = wbk; link_bit = lnk;
    if (m_idle) begin
      run     = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      push_step(blank(3'd0));
      m_idle = 1'b0;
    end
    run = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      mem_ack     = (k == fw);
      e           = blank(3'd1);
      e.fetch_req = 1'b1;
      e.ir_load   = mem_ack;
      e.pc_inc    = mem_ack;
      push_step(e);
      if (k == fw) break;
      if (k == MAXW - 1) return;
    end
    run     = rv;
    mem_ack = 1'($urandom_range(0, 1));
    push_step(blank(3'd2));
    if (op == 5'b11111) return;
    if (!m_cond(cnd, fl)) begin
      retire_m(rv);
      return;
    end
    mem_ack = 1'($urandom_range(0, 1));
    e = blank(3'd3);
    if (op < 5'd16) begin
      cmp        = (op >= 5'd8) && (op <= 5'd11);
      e.alu_en   = 1'b1;
      e.flags_we = s || cmp;
      e.rf_we    = !cmp;
      push_step(e);
      retire_m(rv);
      return;
    end
    if (op == 5'd17) begin
      e.pc_branch = 1'b1;
      e.rf_we     = lnk;
      e.rf_wsel   = lnk ? 2'd3 : 2'd0;
      push_step(e);
      retire_m(rv);
      return;
    end
    e.alu_en = 1'b1;
    push_step(e);
    base = wbk || !pp;
    for (int k = 0; k < 1000; k++) begin
      if (k == abort_mem_k) begin
        mem_ack = 1'b0;
        reset   = 1'b0;
        m_cnt   = 0;
        push_step(blank(3'd0));
        push_step(blank(3'd0));
        reset  = 1'b1;
        m_idle = 1'b1;
        return;
      end
      mem_ack    = (k == mw);
      e          = blank(3'd4);
      e.mem_req  = 1'b1;
      e.mem_we   = !ls;
      e.addr_sel = pp ? 2'd2 : 2'd1;
      push_step(e);
      if (k == mw) break;
      if (k == MAXW - 1) return;
    end
    if (ls) begin
      mem_ack   = 1'($urandom_range(0, 1));
      e         = blank(3'd5);
      e.rf_we   = 1'b1;
      e.rf_wsel = 2'd1;
      push_step(e);
    end
    if (base) begin
      mem_ack   = 1'($urandom_range(0, 1));
      e         = blank(3'd6);
      e.rf_we   = 1'b1;
      e.rf_wsel = 2'd2;
      push_step(e);
    end
    retire_m(rv);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    int         kind;
    reset = 1'b0; run = 1'b0; opcode = '0; cond = '0; flags = '0; cpsr_write = 1'b0;
    load_store = 1'b0; pre_post = 1'b0; write_back = 1'b0; link_bit = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // ADDS, CMP EQ failing and passing, LDR post-index with slow ack, BL
    run_instr(5'b00100, 4'hE, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1);
    run_instr(5'b01010, 4'h0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
    run_instr(5'b01010, 4'h0, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1);
    run_instr(5'b10000, 4'hE, 4'h0, 0, 1, 0, 0, 0, 0, 3, 1);
    run_instr(5'b10001, 4'hE, 4'h0, 0, 0, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      op   = (kind < 2) ? 5'($urandom_range(0, 15)) : ((kind == 2) ? 5'b10000 : 5'b10001);
      run_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0));
      if (m_idle && ($urandom_range(0, 1) == 1)) idle_hold(2);
    end

    // run dropped during EXEC: retire then park in IDLE
    run_instr(5'b00001, 4'hE, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_hold(3);

    // Store with ack exactly on the last allowed MEM cycle: no fault
    run_instr(5'b10000, 4'hE, 4'h0, 0, 0, 1, 0, 0, 0, MAXW - 1, 1);
    // Store with no ack: FAULT after MAXW cycles in MEM
    run_instr(5'b10000, 4'hE, 4'h0, 0, 0, 1, 0, 0, 0, 50, 1);
    fault_cycles(3);
    do_reset();

    // Reset asserted mid-MEM aborts and clears immediately
    run_instr(5'b00100, 4'hE, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    abort_mem_k = 2;
    run_instr(5'b10000, 4'hE, 4'h0, 0, 1, 1, 1, 0, 0, 3, 1);
    abort_mem_k = -1;
    run_instr(5'b00100, 4'hE, 4'h0, 1, 0, 0, 0, 0, 1, 0, 1);

    // FETCH timeout
    run_instr(5'b00100, 4'hE, 4'h0, 0, 0, 0, 0, 0, 50, 0, 1);
    fault_cycles(2);
    do_reset();

    // Invalid opcode: sticky fault while run stays high
    run_instr(5'b11111, 4'hE, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    fault_cycles(20);
    do_reset();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
